// File: rtl/alu_console_pkg.sv
// rtl/alu_console_pkg.sv - shared types and constants for the button-driven ALU console
package alu_console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_OP   = 2;
    localparam int BTN_EXEC = 3;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // The debounce counter must be able to hold the value DEBOUNCE_CYCLES itself.
    function automatic int deb_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational ALU datapath producing result, carry and zero
module ALU #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6
) (
    input  logic [NB_DATA-1:0]    i_data_a,
    input  logic [NB_DATA-1:0]    i_data_b,
    input  logic [NB_OP_CODE-1:0] i_op_code,
    output logic [NB_DATA-1:0]    o_result,
    output logic                  o_carry,
    output logic                  o_zero
);

    localparam logic [NB_OP_CODE-1:0] C_ADD = NB_OP_CODE'(6'b100000);
    localparam logic [NB_OP_CODE-1:0] C_SUB = NB_OP_CODE'(6'b100010);
    localparam logic [NB_OP_CODE-1:0] C_AND = NB_OP_CODE'(6'b100100);
    localparam logic [NB_OP_CODE-1:0] C_OR  = NB_OP_CODE'(6'b100101);
    localparam logic [NB_OP_CODE-1:0] C_XOR = NB_OP_CODE'(6'b100110);
    localparam logic [NB_OP_CODE-1:0] C_NOR = NB_OP_CODE'(6'b100111);
    localparam logic [NB_OP_CODE-1:0] C_SRA = NB_OP_CODE'(6'b000011);
    localparam logic [NB_OP_CODE-1:0] C_SRL = NB_OP_CODE'(6'b000010);

    logic [NB_DATA:0]          wide;
    logic signed [NB_DATA-1:0] sra_val;

    assign sra_val = $signed(i_data_a) >>> i_data_b;

    // Bit NB_DATA of the widened value is carry for ADD and borrow for SUB.
    always_comb begin
        wide = '0;
        case (i_op_code)
            C_ADD:   wide = {1'b0, i_data_a} + {1'b0, i_data_b};
            C_SUB:   wide = {1'b0, i_data_a} - {1'b0, i_data_b};
            C_AND:   wide = {1'b0, i_data_a & i_data_b};
            C_OR:    wide = {1'b0, i_data_a | i_data_b};
            C_XOR:   wide = {1'b0, i_data_a ^ i_data_b};
            C_NOR:   wide = {1'b0, ~(i_data_a | i_data_b)};
            C_SRA:   wide = {1'b0, sra_val};
            C_SRL:   wide = {1'b0, i_data_a >> i_data_b};
            default: wide = '0;
        endcase
    end

    assign o_result = wide[NB_DATA-1:0];
    assign o_carry  = wide[NB_DATA];
    assign o_zero   = (wide[NB_DATA-1:0] == '0);

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and rising-edge strobe
module btn_debounce
    import alu_console_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_strobe
);

    localparam int               CNT_W   = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = i_btn;
        sync2_d      = sync1_q;
        level_d      = level_q;
        level_prev_d = level_q;
        cnt_d        = '0;
        // Any cycle where synced input agrees with the level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        strobe_d = level_q & ~level_prev_q;
    end

    always_ff @(posedge clock) begin
        if (i_rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            strobe_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            strobe_q     <= strobe_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_strobe = strobe_q;

endmodule

// File: rtl/alu_console.sv
// rtl/alu_console.sv - button/switch console sequencing loads and execution of the ALU
module alu_console
    import alu_console_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_OP_CODE      = 6,
    parameter int NB_BTN          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NB_COUNT        = 8
) (
    input  logic                clock,
    input  logic                i_rst,
    input  logic [NB_BTN-1:0]   i_btn,
    input  logic [NB_DATA-1:0]  i_sw_data,
    input  logic                i_acc_mode,
    output logic [NB_DATA+1:0]  o_led,
    output logic                o_valid,
    output logic [1:0]          o_state,
    output logic [NB_COUNT-1:0] o_exec_count
);

    logic [NB_BTN-1:0] strobe;

    for (genvar g = 0; g < NB_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock   (clock),
            .i_rst   (i_rst),
            .i_btn   (i_btn[g]),
            .o_strobe(strobe[g])
        );
    end

    state_t                state_q, state_d;
    logic [NB_DATA-1:0]    a_q, a_d;
    logic [NB_DATA-1:0]    b_q, b_d;
    logic [NB_OP_CODE-1:0] op_q, op_d;
    logic [NB_DATA+1:0]    led_q, led_d;
    logic                  valid_q, valid_d;
    logic [NB_COUNT-1:0]   count_q, count_d;

    logic [NB_DATA-1:0] alu_result;
    logic               alu_carry;
    logic               alu_zero;

    ALU #(
        .NB_DATA   (NB_DATA),
        .NB_OP_CODE(NB_OP_CODE)
    ) u_alu (
        .i_data_a (a_q),
        .i_data_b (b_q),
        .i_op_code(op_q),
        .o_result (alu_result),
        .o_carry  (alu_carry),
        .o_zero   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        led_d   = led_q;
        valid_d = 1'b0;
        count_d = count_q;
        case (state_q)
            ST_EXEC: begin
                // Strobes in this cycle are intentionally ignored.
                led_d   = {alu_zero, alu_carry, alu_result};
                valid_d = 1'b1;
                count_d = count_q + NB_COUNT'(1);
                if (i_acc_mode) begin
                    a_d = alu_result;
                end
                state_d = ST_HOLD;
            end
            default: begin
                // IDLE, HOLD and the unused encoding share load/exec handling;
                // only the highest-priority strobe acts, the rest are dropped.
                if (strobe[BTN_A]) begin
                    a_d     = i_sw_data;
                    state_d = ST_IDLE;
                end else if (strobe[BTN_B]) begin
                    b_d     = i_sw_data;
                    state_d = ST_IDLE;
                end else if (strobe[BTN_OP]) begin
                    op_d    = i_sw_data[NB_OP_CODE-1:0];
                    state_d = ST_IDLE;
                end else if (strobe[BTN_EXEC]) begin
                    state_d = ST_EXEC;
                end else if (state_q != ST_HOLD) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            led_q   <= led_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign o_led        = led_q;
    assign o_valid      = valid_q;
    assign o_state      = state_q;
    assign o_exec_count = count_q;

endmodule

// File: tb/tb_alu_console.sv
// tb/tb_alu_console.sv - directed self-checking bench for alu_console
module tb_alu_console
    import alu_console_pkg::*;
;

    logic       clock = 1'b0;
    logic       i_rst;
    logic [3:0] i_btn;
    logic [7:0] i_sw_data;
    logic       i_acc_mode;
    logic [9:0] o_led;
    logic       o_valid;
    logic [1:0] o_state;
    logic [7:0] o_exec_count;

    int n_cmp = 0;
    int n_err = 0;
    int strobe0_cnt = 0;
    int valid_cnt = 0;
    int base;

    always #5 clock = ~clock;

    alu_console #(
        .NB_DATA        (8),
        .NB_OP_CODE     (6),
        .NB_BTN         (4),
        .DEBOUNCE_CYCLES(4),
        .NB_COUNT       (8)
    ) dut (
        .clock       (clock),
        .i_rst       (i_rst),
        .i_btn       (i_btn),
        .i_sw_data   (i_sw_data),
        .i_acc_mode  (i_acc_mode),
        .o_led       (o_led),
        .o_valid     (o_valid),
        .o_state     (o_state),
        .o_exec_count(o_exec_count)
    );

    always @(negedge clock) begin
        if (dut.strobe[BTN_A]) strobe0_cnt = strobe0_cnt + 1;
        if (o_valid) valid_cnt = valid_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx, input logic [7:0] sw);
        @(negedge clock);
        i_sw_data  = sw;
        i_btn[idx] = 1'b1;
        repeat (10) @(negedge clock);
        i_btn[idx] = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_btn      = 4'b0;
        i_sw_data  = 8'h00;
        i_acc_mode = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_led", o_led, 10'h000);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_count", o_exec_count, 8'd0);
        chk("rst_state", o_state, 2'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge clock);

        // Basic ADD with strobe latency check on EXEC
        press(BTN_A, 8'h05);
        press(BTN_B, 8'h03);
        press(BTN_OP, {2'b00, OP_ADD});
        chk("load_led_unchanged", o_led, 10'h000);
        chk("load_state_idle", o_state, 2'd0);
        @(negedge clock);
        i_btn[BTN_EXEC] = 1'b1;
        repeat (7) @(negedge clock);
        chk("exec_strobe_k6", dut.strobe[BTN_EXEC], 1'b0);
        @(negedge clock);
        chk("exec_strobe_k7", dut.strobe[BTN_EXEC], 1'b1);
        @(negedge clock);
        chk("exec_strobe_k8", dut.strobe[BTN_EXEC], 1'b0);
        chk("exec_state_exec", o_state, 2'd1);
        @(negedge clock);
        chk("add_led", o_led, 10'h008);
        chk("add_valid", o_valid, 1'b1);
        chk("add_count", o_exec_count, 8'd1);
        chk("add_state_hold", o_state, 2'd2);
        @(negedge clock);
        chk("add_valid_drop", o_valid, 1'b0);
        i_btn[BTN_EXEC] = 1'b0;
        repeat (10) @(negedge clock);

        // Bouncing button: no load until the level is stable
        i_sw_data = 8'hAA;
        base = strobe0_cnt;
        for (int i = 0; i < 10; i++) begin
            i_btn[BTN_A] = ~i_btn[BTN_A];
            repeat (2) @(negedge clock);
        end
        chk("bounce_no_strobe", strobe0_cnt - base, 0);
        chk("bounce_a_kept", dut.a_q, 8'h05);
        i_btn[BTN_A] = 1'b1;
        repeat (8) @(negedge clock);
        chk("bounce_strobe_k7", dut.strobe[BTN_A], 1'b1);
        @(negedge clock);
        chk("bounce_a_loaded", dut.a_q, 8'hAA);
        chk("bounce_one_strobe", strobe0_cnt - base, 1);
        i_btn[BTN_A] = 1'b0;
        repeat (10) @(negedge clock);
        chk("release_no_strobe", strobe0_cnt - base, 1);

        // Accumulate mode
        i_acc_mode = 1'b1;
        press(BTN_A, 8'hF0);
        press(BTN_B, 8'h20);
        press(BTN_OP, {2'b00, OP_ADD});
        press(BTN_EXEC, 8'h00);
        chk("acc1_led", o_led, 10'h110);
        chk("acc1_a", dut.a_q, 8'h10);
        press(BTN_EXEC, 8'h00);
        chk("acc2_led", o_led, 10'h030);
        chk("acc2_a", dut.a_q, 8'h30);
        chk("acc2_count", o_exec_count, 8'd3);
        i_acc_mode = 1'b0;

        // Zero flag from AND
        press(BTN_A, 8'h0F);
        chk("hold_load_idle", o_state, 2'd0);
        chk("hold_load_led", o_led, 10'h030);
        press(BTN_B, 8'hF0);
        press(BTN_OP, {2'b00, OP_AND});
        press(BTN_EXEC, 8'h00);
        chk("zero_led", o_led, 10'h200);
        chk("zero_count", o_exec_count, 8'd4);

        // Simultaneous A and B presses: only A acts
        @(negedge clock);
        i_sw_data = 8'h11;
        i_btn[BTN_A] = 1'b1;
        i_btn[BTN_B] = 1'b1;
        repeat (10) @(negedge clock);
        i_btn = 4'b0;
        repeat (10) @(negedge clock);
        chk("simul_a", dut.a_q, 8'h11);
        chk("simul_b", dut.b_q, 8'hF0);

        // Reset during EXEC
        i_rst = 1'b1;
        repeat (2) @(negedge clock);
        i_rst = 1'b0;
        chk("rst2_count", o_exec_count, 8'd0);
        chk("rst2_led", o_led, 10'h000);
        i_btn[BTN_EXEC] = 1'b1;
        repeat (9) @(negedge clock);
        chk("midexec_state", o_state, 2'd1);
        i_rst = 1'b1;
        i_btn = 4'b0;
        @(negedge clock);
        chk("midexec_valid", o_valid, 1'b0);
        chk("midexec_count", o_exec_count, 8'd0);
        chk("midexec_state_idle", o_state, 2'd0);
        chk("midexec_led", o_led, 10'h000);
        i_rst = 1'b0;
        repeat (12) @(negedge clock);
        chk("valid_pulses_total", valid_cnt, 4);
        chk("final_count", o_exec_count, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
